cpu_bus_xbar: RTL and testbench

Parametrised successor to the CPU bus address decoder. Sits between the CPU load/store unit and NSLAVE memory-mapped targets (SDRAM controller, LED register, VGA memory, keyboard, ...). Latches each CPU request and decodes it against per-slave base/size windows. It then drives a held request to the selected slave, waits for that slave's ready, and returns read data with a one-cycle READY pulse. Unmapped addresses and slave timeouts complete with ERR instead of hanging the CPU.

---
 rtl/cpu_bus_xbar_if.sv | 31 +++
 rtl/cpu_bus_xbar.sv | 143 ++++++++++++++
 tb/tb_cpu_bus_xbar.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_xbar_if.sv
// CPU-side request/response bus plus per-slave request/response lines of the bus crossbar.
// The crossbar takes the slave modport; the CPU and the slave models take the master modport.
interface cpu_bus_xbar_if #(
    parameter int unsigned NSLAVE = 4,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32
);
    logic [AW-1:0]        address;
    logic [DW-1:0]        wdata;
    logic [1:0]           WLEN;
    logic                 EN_N;
    logic                 READY;
    logic [DW-1:0]        rdata;
    logic                 ERR;
    logic [NSLAVE-1:0]    s_sel;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_wdata;
    logic [1:0]           s_wlen;
    logic [NSLAVE-1:0]    s_ready;
    logic [NSLAVE*DW-1:0] s_rdata;

    modport master (
        output address, wdata, WLEN, EN_N, s_ready, s_rdata,
        input  READY, rdata, ERR, s_sel, s_addr, s_wdata, s_wlen
    );

    modport slave (
        input  address, wdata, WLEN, EN_N, s_ready, s_rdata,
        output READY, rdata, ERR, s_sel, s_addr, s_wdata, s_wlen
    );
endinterface

// File: rtl/cpu_bus_xbar.sv
// Address-decoding bus crossbar: latches a CPU request, holds it on the selected slave until
// that slave is ready, and completes with a one-cycle READY (ERR on decode miss or timeout).
module cpu_bus_xbar #(
    parameter int unsigned          NSLAVE  = 4,
    parameter int unsigned          AW      = 32,
    parameter int unsigned          DW      = 32,
    parameter logic [NSLAVE*AW-1:0] BASES   = {32'h4009614, 32'h4000004, 32'h4000000, 32'h0},
    parameter logic [NSLAVE*AW-1:0] SIZES   = {32'h10, 32'h9610, 32'h4, 32'h4000000},
    parameter int unsigned          TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    cpu_bus_xbar_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [NSLAVE-1:0] sel_q, sel_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [1:0]        wlen_q, wlen_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [AW-1:0]     off [NSLAVE];
    logic [NSLAVE-1:0] win;
    logic [NSLAVE-1:0] hit;
    logic [AW-1:0]     hit_off;
    logic [DW-1:0]     sel_rdata;

    // Offset wraps in AW bits, so a window ending exactly at 2^AW still decodes.
    always_comb begin
        for (int i = 0; i < NSLAVE; i++) begin
            off[i] = bus.address - BASES[i*AW +: AW];
            win[i] = (SIZES[i*AW +: AW] != '0) && (bus.address >= BASES[i*AW +: AW]) &&
                     (off[i] < SIZES[i*AW +: AW]);
        end
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = '0;
        hit_off = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if (win[i]) begin
                hit     = '0;
                hit[i]  = 1'b1;
                hit_off = off[i];
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.s_rdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wlen_d  = wlen_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (!bus.EN_N) begin
                    sel_d   = hit;
                    addr_d  = hit_off;
                    wdata_d = bus.wdata;
                    wlen_d  = bus.WLEN;
                    cnt_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // A decode miss spends one cycle here with nothing selected, so its READY
                // arrives with the same latency as the fastest hit.
                if (sel_q == '0) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if ((bus.s_ready & sel_q) != '0) begin
                    rdata_d = (wlen_q == 2'b00) ? sel_rdata : '0;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    state_d = StDone;
                end else if ((TIMEOUT != 0) && (32'(cnt_q) + 32'd1 == TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wlen_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wlen_q  <= wlen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.READY   = (state_q == StDone);
    assign bus.rdata   = rdata_q;
    assign bus.ERR     = err_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.s_wlen  = wlen_q;
endmodule

// File: tb/tb_cpu_bus_xbar.sv
// Directed bench for cpu_bus_xbar: vector table of single transactions plus hand-written
// back-to-back and reset-abort sequences, with TIMEOUT=4 and the default address map.
module tb_cpu_bus_xbar;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   ready_cnt = 0;

    cpu_bus_xbar_if #(.NSLAVE(4), .AW(32), .DW(32)) bus ();

    cpu_bus_xbar #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.READY) ready_cnt <= ready_cnt + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  wlen;
        int          rdy_at;  // selected cycle on which the slave answers, 0 = never
        logic [31:0] sdata;
        logic [3:0]  sel;
        logic [31:0] saddr;
        logic [31:0] rdata;
        logic        err;
        int          lat;     // edges from request edge to the READY cycle
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        for (int i = 0; i < 4; i++)
            bus.s_rdata[i*32 +: 32] = v.sel[i] ? v.sdata : (32'hBAD0_0000 | 32'(i));
        bus.address = v.addr;
        bus.wdata   = v.wdata;
        bus.WLEN    = v.wlen;
        bus.EN_N    = 1'b0;
        bus.s_ready = 4'b0000;
        tick();
        // Request fields change after the request edge; the latched copies must not.
        bus.EN_N    = 1'b1;
        bus.address = ~v.addr;
        bus.wdata   = ~v.wdata;
        bus.WLEN    = ~v.wlen;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.READY) begin
                lat = n;
                break;
            end
            check($sformatf("vec%0d s_sel c%0d", idx, n), 32'(bus.s_sel), 32'(v.sel));
            if (v.sel != 4'b0000) begin
                check($sformatf("vec%0d s_addr c%0d", idx, n), bus.s_addr, v.saddr);
                check($sformatf("vec%0d s_wdata c%0d", idx, n), bus.s_wdata, v.wdata);
                check($sformatf("vec%0d s_wlen c%0d", idx, n), 32'(bus.s_wlen), 32'(v.wlen));
            end
            // Unselected slaves always claim ready; the crossbar must ignore them.
            bus.s_ready = (v.rdy_at == n) ? v.sel : ~v.sel;
            tick();
        end
        check($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("vec%0d rdata", idx), bus.rdata, v.rdata);
        check($sformatf("vec%0d ERR", idx), 32'(bus.ERR), 32'(v.err));
        check($sformatf("vec%0d s_sel at READY", idx), 32'(bus.s_sel), 32'd0);
        bus.s_ready = 4'b0000;
        tick();
        check($sformatf("vec%0d READY one cycle", idx), 32'(bus.READY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h100, 32'h0, 2'b00, 3, 32'hDEADBEEF, 4'b0001, 32'h100, 32'hDEADBEEF,
                    1'b0, 4};
        vecs[1] = '{32'h4000010, 32'h1234, 2'b11, 1, 32'h5555AAAA, 4'b0100, 32'hC, 32'h0,
                    1'b0, 2};
        vecs[2] = '{32'hFFFFFFF0, 32'h0, 2'b00, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 2};
        vecs[3] = '{32'h4000000, 32'h0, 2'b00, 0, 32'h13579BDF, 4'b0010, 32'h0, 32'h0, 1'b1, 5};
        vecs[4] = '{32'h4009623, 32'h0, 2'b00, 2, 32'hCAFEF00D, 4'b1000, 32'hF, 32'hCAFEF00D,
                    1'b0, 3};
        vecs[5] = '{32'h4009624, 32'h0, 2'b00, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 2};
        vecs[6] = '{32'h4000003, 32'h0, 2'b00, 4, 32'h0BADCAFE, 4'b0010, 32'h3, 32'h0BADCAFE,
                    1'b0, 5};
        vecs[7] = '{32'h3FFFFFF, 32'hBEEF, 2'b10, 1, 32'h77777777, 4'b0001, 32'h3FFFFFF, 32'h0,
                    1'b0, 2};

        rst         = 1'b1;
        bus.address = '0;
        bus.wdata   = '0;
        bus.WLEN    = 2'b00;
        bus.EN_N    = 1'b1;
        bus.s_ready = '0;
        bus.s_rdata = '0;
        #3;
        check("reset READY", 32'(bus.READY), 32'd0);
        check("reset ERR", 32'(bus.ERR), 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        check("reset s_sel", 32'(bus.s_sel), 32'd0);
        check("reset s_addr", bus.s_addr, 32'd0);
        check("reset s_wdata", bus.s_wdata, 32'd0);
        check("reset s_wlen", 32'(bus.s_wlen), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle READY", 32'(bus.READY), 32'd0);

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Back-to-back with EN_N held low, alternating slave 0 top byte and slave 1 top byte.
        begin
            int r0;
            r0 = ready_cnt;
            bus.s_rdata = {32'hBAD0_0003, 32'hBAD0_0002, 32'h1111_0001, 32'h0000_0AAA};
            bus.WLEN    = 2'b00;
            bus.address = 32'h3FFFFFF;
            bus.EN_N    = 1'b0;
            for (int k = 0; k < 4; k++) begin
                logic [3:0]  esel;
                logic [31:0] eoff;
                logic [31:0] edat;
                esel = (k % 2 == 0) ? 4'b0001 : 4'b0010;
                eoff = (k % 2 == 0) ? 32'h3FFFFFF : 32'h3;
                edat = (k % 2 == 0) ? 32'h0000_0AAA : 32'h1111_0001;
                tick();
                check($sformatf("b2b%0d s_sel", k), 32'(bus.s_sel), 32'(esel));
                check($sformatf("b2b%0d s_addr", k), bus.s_addr, eoff);
                bus.s_ready = esel;
                bus.address = (k % 2 == 0) ? 32'h4000003 : 32'h3FFFFFF;
                tick();
                check($sformatf("b2b%0d READY", k), 32'(bus.READY), 32'd1);
                check($sformatf("b2b%0d rdata", k), bus.rdata, edat);
                check($sformatf("b2b%0d ERR", k), 32'(bus.ERR), 32'd0);
                bus.s_ready = 4'b0000;
                if (k == 3) bus.EN_N = 1'b1;
                tick();
                check($sformatf("b2b%0d idle READY", k), 32'(bus.READY), 32'd0);
                check($sformatf("b2b%0d idle s_sel", k), 32'(bus.s_sel), 32'd0);
            end
            tick();
            check("b2b no extra txn", 32'(bus.s_sel), 32'd0);
            check("b2b READY count", 32'(ready_cnt - r0), 32'd4);
        end

        // Reset while slave 0 is being held: selection drops at once and no READY follows.
        bus.s_rdata = {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'h600D_0000};
        bus.address = 32'h100;
        bus.WLEN    = 2'b00;
        bus.EN_N    = 1'b0;
        bus.s_ready = 4'b0000;
        tick();
        bus.EN_N = 1'b1;
        check("rst-abort s_sel before", 32'(bus.s_sel), 32'b0001);
        tick();
        check("rst-abort s_sel held", 32'(bus.s_sel), 32'b0001);
        #2;
        rst = 1'b1;
        #1;
        check("rst-abort s_sel async", 32'(bus.s_sel), 32'd0);
        check("rst-abort READY", 32'(bus.READY), 32'd0);
        check("rst-abort rdata", bus.rdata, 32'd0);
        tick();
        tick();
        check("rst-abort READY held", 32'(bus.READY), 32'd0);
        rst = 1'b0;
        tick();
        check("rst-abort READY after", 32'(bus.READY), 32'd0);
        run_vec(8, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
